add_exec_pipe: RTL and testbench

- Two-stage pipelined WIDTH-bit add/subtract execution slot for the VLIW datapath.
- Consumes issued operand pairs and produces registered sum, carry and flags to writeback.
- Carry is split across halves: low half added in stage 1, high half in stage 2 using the registered low-half carry.
- Valid/ready handshake on both sides, with full backpressure.

---
 rtl/add_exec_pipe.sv | 162 ++++++++++++++++
 tb/tb_add_exec_pipe.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/add_exec_pipe.sv
// Two-stage split-carry add/sub execution slot with valid/ready on both sides.
// Optional: define ADD_EXEC_SAT_EN for signed saturation on ADD and SUB.
`timescale 1ns/1ps
module add_exec_pipe #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [1:0]       in_op,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_zero,
   output logic             cflag
);

   localparam int HALF = WIDTH / 2;

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_ADC  = 2'b10;
   localparam logic [1:0] OP_ADDX = 2'b11;

   typedef struct packed {
      logic [HALF-1:0] lo;
      logic            c1;
      logic [HALF-1:0] a_hi;
      logic [HALF-1:0] b_hi;
`ifdef ADD_EXEC_SAT_EN
      logic            sat;
`endif
   } s1_t;

   s1_t             s1_q;
   s1_t             s1_d;
   logic            s1_valid;
   logic            s2_load;
   logic            in_fire;
   logic            adc_block;

   logic            is_add;
   logic            is_sub;
   logic            is_adc;
   logic            is_addx;
   logic [WIDTH-1:0] bx;
   logic            c0;
   logic [HALF:0]   lo_sum;

   logic [HALF:0]   hi_sum;
   logic [WIDTH-1:0] sum_w;
   logic [WIDTH-1:0] sum_n;
   logic            ovf_n;

   assign is_add  = (in_op == OP_ADD);
   assign is_sub  = (in_op == OP_SUB);
   assign is_adc  = (in_op == OP_ADC);
   assign is_addx = (in_op == OP_ADDX);

   // ADC must see the flag of the op ahead of it, so it waits for a drained pipe
   assign adc_block = is_adc & (s1_valid | out_valid);
   assign s2_load   = s1_valid & (~out_valid | out_ready);
   assign in_ready  = (~s1_valid | s2_load) & ~adc_block;
   assign in_fire   = in_valid & in_ready;

   always_comb begin
      bx = in_b;
      c0 = 1'b0;
      unique case (1'b1)
         is_add:  c0 = 1'b0;
         is_sub:  begin
            bx = ~in_b;
            c0 = 1'b1;
         end
         is_adc:  c0 = cflag;
         is_addx: c0 = in_cin;
         default: c0 = 1'b0;
      endcase
   end

   assign lo_sum = {1'b0, in_a[HALF-1:0]}
                 + {1'b0, bx[HALF-1:0]}
                 + {{HALF{1'b0}}, c0};

   always_comb begin
      s1_d      = '0;
      s1_d.lo   = lo_sum[HALF-1:0];
      s1_d.c1   = lo_sum[HALF];
      s1_d.a_hi = in_a[WIDTH-1:HALF];
      s1_d.b_hi = bx[WIDTH-1:HALF];
`ifdef ADD_EXEC_SAT_EN
      s1_d.sat  = is_add | is_sub;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
      end else if (in_fire) begin
         s1_valid <= 1'b1;
         s1_q     <= s1_d;
      end else if (s2_load) begin
         s1_valid <= 1'b0;
      end
   end

   assign hi_sum = {1'b0, s1_q.a_hi}
                 + {1'b0, s1_q.b_hi}
                 + {{HALF{1'b0}}, s1_q.c1};

   assign sum_w = {hi_sum[HALF-1:0], s1_q.lo};
   assign ovf_n = (s1_q.a_hi[HALF-1] == s1_q.b_hi[HALF-1])
                & (hi_sum[HALF-1] != s1_q.a_hi[HALF-1]);

`ifdef ADD_EXEC_SAT_EN
   always_comb begin
      sum_n = sum_w;
      if (s1_q.sat & ovf_n) begin
         if (s1_q.a_hi[HALF-1])
            sum_n = {1'b1, {(WIDTH-1){1'b0}}};
         else
            sum_n = {1'b0, {(WIDTH-1){1'b1}}};
      end
   end
`else
   assign sum_n = sum_w;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_cout  <= 1'b0;
         out_ovf   <= 1'b0;
         out_zero  <= 1'b0;
      end else if (s2_load) begin
         out_valid <= 1'b1;
         out_sum   <= sum_n;
         out_cout  <= hi_sum[HALF];
         out_ovf   <= ovf_n;
         out_zero  <= (sum_n == '0);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Flag follows the result leaving the slot, even if a new one replaces it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cflag <= 1'b0;
      else if (out_valid & out_ready)
         cflag <= out_cout;
   end

endmodule

// File: tb/tb_add_exec_pipe.sv
// Directed self-checking bench for add_exec_pipe (WIDTH=64).
// Expected values are hand-computed constants.
`timescale 1ns/1ps
module tb_add_exec_pipe;

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_ADC  = 2'b10;
   localparam logic [1:0] OP_ADDX = 2'b11;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_a;
   logic [63:0] in_b;
   logic [1:0]  in_op;
   logic        in_cin;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_sum;
   logic        out_cout;
   logic        out_ovf;
   logic        out_zero;
   logic        cflag;

   int checks;
   int failures;

   logic [63:0] bp_exp [4];
   logic [63:0] max_pos_exp;
   logic [63:0] min_neg_exp;

   add_exec_pipe #(.WIDTH(64)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_op     (in_op),
      .in_cin    (in_cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf),
      .out_zero  (out_zero),
      .cflag     (cflag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [1:0] op,
                       input logic [63:0] a,
                       input logic [63:0] b,
                       input logic ci);
      int  n;
      logic ok;
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      in_cin   = ci;
      n  = 0;
      ok = 1'b0;
      while (!ok && n < 40) begin
         @(negedge clk);
         #2;
         ok = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      in_op    = OP_ADD;
      if (!ok) chk("send_timeout", 64'(ok), 64'd1);
   endtask

   task automatic recv(input string tag,
                       input logic [63:0] sum,
                       input logic co,
                       input logic ov,
                       input logic z);
      int n;
      n = 0;
      while (!out_valid && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({tag, "_v"},    64'(out_valid), 64'd1);
      chk({tag, "_sum"},  out_sum,         sum);
      chk({tag, "_cout"}, 64'(out_cout),   64'(co));
      chk({tag, "_ovf"},  64'(out_ovf),    64'(ov));
      chk({tag, "_zero"}, 64'(out_zero),   64'(z));
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_op     = OP_ADD;
      in_cin    = 1'b0;
      out_ready = 1'b1;
`ifdef ADD_EXEC_SAT_EN
      max_pos_exp = 64'h7FFF_FFFF_FFFF_FFFF;
      min_neg_exp = 64'h8000_0000_0000_0000;
`else
      max_pos_exp = 64'h8000_0000_0000_0000;
      min_neg_exp = 64'h7FFF_FFFF_FFFF_FFFF;
`endif

      #12;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_sum",   out_sum,         64'd0);
      chk("rst_cout",      64'(out_cout),   64'd0);
      chk("rst_ovf",       64'(out_ovf),    64'd0);
      chk("rst_zero",      64'(out_zero),   64'd0);
      chk("rst_cflag",     64'(cflag),      64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_in_ready", 64'(in_ready), 64'd1);

      // latency: handshake edge, nothing out one edge later, valid the next
      send(OP_ADD, 64'd21, 64'd20, 1'b0);
      chk("lat_e1", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      chk("lat_e2", 64'(out_valid), 64'd1);
      recv("add41", 64'd41, 1'b0, 1'b0, 1'b0);

      send(OP_ADD, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0);
      recv("half_carry", 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0);

      // ADC interlock
      send(OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd92182163, 1'b0);
      in_valid = 1'b1;
      in_op    = OP_ADC;
      in_a     = 64'd0;
      in_b     = 64'd0;
      #1;
      chk("adc_blk_s1", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      chk("adc_blk_s2",   64'(in_ready), 64'd0);
      chk("adc_pre_sum",  out_sum,        64'd92182162);
      chk("adc_pre_cout", 64'(out_cout),  64'd1);
      @(posedge clk);
      #1;
      chk("adc_cflag1",  64'(cflag),     64'd1);
      chk("adc_drained", 64'(out_valid), 64'd0);
      chk("adc_ready",   64'(in_ready),  64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_op    = OP_ADD;
      recv("adc", 64'd1, 1'b0, 1'b0, 1'b0);
      chk("adc_cflag0", 64'(cflag), 64'd0);

      send(OP_ADDX, 64'd10, 64'd20, 1'b1);
      recv("addx", 64'd31, 1'b0, 1'b0, 1'b0);

      send(OP_SUB, 64'd5, 64'd7, 1'b0);
      recv("sub_neg", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
      send(OP_SUB, 64'd7, 64'd7, 1'b0);
      recv("sub_zero", 64'd0, 1'b1, 1'b0, 1'b1);
      send(OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
      recv("add_ovf", max_pos_exp, 1'b0, 1'b1, 1'b0);
      send(OP_SUB, 64'h8000_0000_0000_0000, 64'd1, 1'b0);
      recv("sub_ovf", min_neg_exp, 1'b1, 1'b1, 1'b0);

      // backpressure: 4 back-to-back ADDs, out_ready low for 3 cycles
      for (int i = 0; i < 4; i++)
         bp_exp[i] = 64'(i * 1000 + 7) + 64'(i);
      out_ready = 1'b1;
      fork
         begin
            for (int i = 0; i < 4; i++)
               send(OP_ADD, 64'(i * 1000 + 7), 64'(i), 1'b0);
         end
         begin
            int cyc;
            int got;
            cyc = 0;
            got = 0;
            while (got < 4 && cyc < 60) begin
               @(negedge clk);
               out_ready = !(cyc >= 2 && cyc <= 4);
               if (cyc >= 2 && cyc <= 4) begin
                  chk("bp_hold_v",   64'(out_valid), 64'd1);
                  chk("bp_hold_sum", out_sum,         bp_exp[0]);
               end
               if (cyc == 3)
                  chk("bp_in_ready", 64'(in_ready), 64'd0);
               if (out_valid && out_ready) begin
                  chk("bp_data", out_sum, bp_exp[got]);
                  got++;
               end
               cyc++;
            end
            chk("bp_count", 64'(got), 64'd4);
         end
      join
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_empty", 64'(out_valid), 64'd0);

      // reset with two ops in flight
      send(OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
      recv("wrap", 64'd0, 1'b1, 1'b0, 1'b1);
      chk("pre_rst_cflag", 64'(cflag), 64'd1);
      out_ready = 1'b0;
      send(OP_ADD, 64'd1, 64'd2, 1'b0);
      send(OP_ADD, 64'd3, 64'd4, 1'b0);
      chk("inflight_v", 64'(out_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 64'(out_valid), 64'd0);
      chk("arst_cflag", 64'(cflag),     64'd0);
      chk("arst_sum",   out_sum,         64'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         chk("post_rst_idle", 64'(out_valid), 64'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
